// File: rtl/tumble_pkg.sv
// rtl/tumble_pkg.sv - shared colour constants and state encoding for the ball board run controller
package tumble_pkg;

    localparam logic COLOR_BLUE = 1'b0;
    localparam logic COLOR_RED  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_FLIGHT = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } tumble_state_e;

endpackage

// File: rtl/tumble_pulse_timer.sv
// rtl/tumble_pulse_timer.sv - loadable down-counter with expire flag shared by all timed states
module tumble_pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count_o  = count_q;
    assign expire_o = (count_q == '0);

endmodule

// File: rtl/tumble_sequencer.sv
// rtl/tumble_sequencer.sv - run controller issuing colour triggers and tracking ball flights
module tumble_sequencer
    import tumble_pkg::*;
#(
    parameter int PULSE_LEN  = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024,
    parameter int MAX_BALLS  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           first_color,
    input  logic                           stop,
    input  logic                           lever_blue,
    input  logic                           lever_red,
    input  logic                           no_balls,
    output logic                           blue_trigger,
    output logic                           red_trigger,
    output logic                           busy,
    output logic                           done,
    output logic                           fault,
    output logic                           conflict,
    output logic [$clog2(MAX_BALLS+1)-1:0] launched
);

    localparam int LW = $clog2(MAX_BALLS + 1);
    localparam int TW = $clog2(TIMEOUT + PULSE_LEN + GAP_CYCLES + 1);

    tumble_state_e state_q, state_d;
    logic          next_color_q, next_color_d;
    logic [LW-1:0] launched_q, launched_d;
    logic          fault_q, fault_d;
    logic          conflict_q, conflict_d;
    logic          stop_pend_q, stop_pend_d;
    logic          done_q, done_d;
    logic          blue_q, blue_d;
    logic          red_q, red_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic [TW-1:0] tmr_count;
    logic          tmr_expire;

    tumble_pulse_timer #(.WIDTH(TW)) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_o    (tmr_count),
        .expire_o   (tmr_expire)
    );

    // State and sticky status registers; triggers are registered so the board sees clean edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            next_color_q <= COLOR_BLUE;
            launched_q   <= '0;
            fault_q      <= 1'b0;
            conflict_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            done_q       <= 1'b0;
            blue_q       <= 1'b0;
            red_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_color_q <= next_color_d;
            launched_q   <= launched_d;
            fault_q      <= fault_d;
            conflict_q   <= conflict_d;
            stop_pend_q  <= stop_pend_d;
            done_q       <= done_d;
            blue_q       <= blue_d;
            red_q        <= red_d;
        end
    end

    // Next-state logic; a stop seen during LAUNCH is remembered so the pulse finishes intact
    always_comb begin
        state_d      = state_q;
        next_color_d = next_color_q;
        launched_d   = launched_q;
        fault_d      = fault_q;
        conflict_d   = conflict_q;
        stop_pend_d  = stop_pend_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start) begin
                    state_d      = ST_LAUNCH;
                    next_color_d = first_color;
                    launched_d   = '0;
                    fault_d      = 1'b0;
                    conflict_d   = 1'b0;
                    stop_pend_d  = 1'b0;
                end
            end
            ST_LAUNCH: begin
                if (tmr_count == TW'(PULSE_LEN - 1) && launched_q != LW'(MAX_BALLS)) begin
                    launched_d = launched_q + 1'b1;
                end
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tmr_expire) begin
                    stop_pend_d = 1'b0;
                    if (stop_pend_q || stop) begin
                        state_d = ST_IDLE;
                    end else if (no_balls) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FLIGHT;
                    end
                end
            end
            ST_FLIGHT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (lever_blue || lever_red) begin
                    next_color_d = lever_blue ? COLOR_BLUE : COLOR_RED;
                    if (lever_blue && lever_red) begin
                        conflict_d = 1'b1;
                    end
                    state_d = (GAP_CYCLES == 0) ? ST_LAUNCH : ST_GAP;
                end else if (tmr_expire) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    state_d = ST_LAUNCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer reload on every state change, with the duration of the state being entered
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            ST_LAUNCH: tmr_load_val = TW'(PULSE_LEN - 1);
            ST_FLIGHT: tmr_load_val = TW'(TIMEOUT - 1);
            ST_GAP:    tmr_load_val = TW'(GAP_CYCLES - 1);
            default:   tmr_load_val = '0;
        endcase
    end

    // Registered output decode from the upcoming state
    always_comb begin
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        blue_d = (state_d == ST_LAUNCH) && (next_color_d == COLOR_BLUE);
        red_d  = (state_d == ST_LAUNCH) && (next_color_d == COLOR_RED);
    end

    assign blue_trigger = blue_q;
    assign red_trigger  = red_q;
    assign busy         = (state_q == ST_LAUNCH) || (state_q == ST_FLIGHT) || (state_q == ST_GAP);
    assign done         = done_q;
    assign fault        = fault_q;
    assign conflict     = conflict_q;
    assign launched     = launched_q;

endmodule

// File: tb/tb_tumble_sequencer.sv
// tb/tb_tumble_sequencer.sv - self-checking bench for the ball board run controller
module tb_tumble_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       first_color = 1'b0;
    logic       stop = 1'b0;
    logic       lever_blue = 1'b0;
    logic       lever_red = 1'b0;
    logic       no_balls = 1'b0;
    logic       blue_trigger, red_trigger, busy, done, fault, conflict;
    logic [4:0] launched;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic color;
        int   len;
    } pulse_t;

    pulse_t exp_q[$];

    typedef struct {
        logic first_color;
        int   delay;
        int   lever_sel;
        logic exp_color;
        logic exp_conflict;
    } vec_t;

    always #5 clk = ~clk;

    tumble_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .first_color  (first_color),
        .stop         (stop),
        .lever_blue   (lever_blue),
        .lever_red    (lever_red),
        .no_balls     (no_balls),
        .blue_trigger (blue_trigger),
        .red_trigger  (red_trigger),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .conflict     (conflict),
        .launched     (launched)
    );

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Pulse monitor: measures each trigger pulse and compares against the scoreboard
    int   run_len = 0;
    logic run_col = 1'b0;
    always @(negedge clk) begin
        pulse_t e;
        if (!rst_n) begin
            if (run_len != 0) begin
                if (exp_q.size() == 0) begin
                    chk("pulse_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("trunc_color", int'(run_col), int'(e.color));
                end
            end
            run_len = 0;
        end else begin
            if (blue_trigger && red_trigger) begin
                chk("both_triggers", 1, 0);
            end
            if (blue_trigger || red_trigger) begin
                if (run_len == 0) run_col = red_trigger;
                run_len++;
            end else if (run_len != 0) begin
                if (exp_q.size() == 0) begin
                    chk("pulse_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_color", int'(run_col), int'(e.color));
                    if (e.len >= 0) chk("pulse_len", run_len, e.len);
                end
                run_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic c, input int len);
        pulse_t p;
        p.color = c;
        p.len   = len;
        exp_q.push_back(p);
    endtask

    task automatic kick(input logic c);
        expect_pulse(c, 4);
        first_color = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic lever(input int sel);
        lever_blue = (sel != 1);
        lever_red  = (sel != 0);
        tick();
        lever_blue = 1'b0;
        lever_red  = 1'b0;
    endtask

    task automatic wait_fall();
        int n = 0;
        while (!(blue_trigger || red_trigger) && n < 40) begin tick(); n++; end
        while ((blue_trigger || red_trigger) && n < 40) begin tick(); n++; end
        if (n >= 40) chk("wait_fall_timeout", n, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{first_color: 1'b1, delay: 5,  lever_sel: 0, exp_color: 1'b0, exp_conflict: 1'b0};
        vecs[1] = '{first_color: 1'b0, delay: 0,  lever_sel: 1, exp_color: 1'b1, exp_conflict: 1'b0};
        vecs[2] = '{first_color: 1'b0, delay: 3,  lever_sel: 2, exp_color: 1'b0, exp_conflict: 1'b1};
        vecs[3] = '{first_color: 1'b1, delay: 10, lever_sel: 1, exp_color: 1'b1, exp_conflict: 1'b0};
        vecs[4] = '{first_color: 1'b1, delay: 1,  lever_sel: 2, exp_color: 1'b0, exp_conflict: 1'b1};

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_blue", blue_trigger, 0);
        chk("rst_red", red_trigger, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_launched", launched, 0);

        // Table: launch, lever after a delay, second launch ends the run via no_balls
        for (int i = 0; i < 5; i++) begin
            no_balls = 1'b0;
            kick(vecs[i].first_color);
            chk("vec_busy", busy, 1);
            wait_fall();
            repeat (vecs[i].delay) tick();
            expect_pulse(vecs[i].exp_color, 4);
            lever(vecs[i].lever_sel);
            no_balls = 1'b1;
            n = 0;
            while (!(blue_trigger || red_trigger) && n < 20) begin tick(); n++; end
            chk("vec_gap", n, 2);
            wait_fall();
            chk("vec_done", done, 1);
            chk("vec_launched", launched, 2);
            chk("vec_conflict", conflict, int'(vecs[i].exp_conflict));
            chk("vec_busy_end", busy, 0);
            tick();
            chk("vec_done_once", done, 0);
            chk("vec_conflict_hold", conflict, int'(vecs[i].exp_conflict));
        end

        // no_balls during the first pulse: straight to DONE
        no_balls = 1'b1;
        kick(1'b0);
        wait_fall();
        chk("nb_done", done, 1);
        chk("nb_launched", launched, 1);
        chk("nb_busy", busy, 0);
        tick();
        chk("nb_done_once", done, 0);
        no_balls = 1'b0;

        // Flight timeout
        kick(1'b0);
        wait_fall();
        n = 0;
        while (!fault && n < 1100) begin tick(); n++; end
        chk("to_cycles", n, 1024);
        chk("to_busy", busy, 0);
        chk("to_blue", blue_trigger, 0);
        chk("to_red", red_trigger, 0);
        kick(1'b1);
        chk("to_fault_cleared", fault, 0);
        wait_fall();
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        chk("stop_flight_busy", busy, 0);
        tick();
        chk("stop_flight_stays", busy, 0);

        // stop+start while idle starts; stop in LAUNCH cycle 2 keeps the full pulse
        expect_pulse(1'b1, 4);
        first_color = 1'b1;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_idle_busy", busy, 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_launch_red", red_trigger, 1);
        n = 0;
        while (red_trigger && n < 20) begin tick(); n++; end
        chk("stop_launch_rest", n, 2);
        chk("stop_launch_busy", busy, 0);
        chk("stop_launch_done", done, 0);
        chk("stop_launch_cnt", launched, 1);

        // Asynchronous reset mid-pulse
        kick(1'b0);
        exp_q[exp_q.size() - 1].len = -1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_blue", blue_trigger, 0);
        chk("arst_red", red_trigger, 0);
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_busy", busy, 0);
        chk("arst_launched", launched, 0);

        // Twenty launches in one run saturate the counter
        no_balls = 1'b0;
        kick(1'b1);
        for (int i = 0; i < 20; i++) begin
            wait_fall();
            chk("sat_launched", launched, (i + 1 > 16) ? 16 : i + 1);
            if (i < 19) begin
                expect_pulse(1'b1, 4);
                lever(1);
                if (i == 18) no_balls = 1'b1;
            end
        end
        chk("sat_done", done, 1);
        no_balls = 1'b0;

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
